uart_mem_boot_ctrl: RTL

- Sequences UART-driven programming of main memory and arbitrates the single memory port between the UART loader and the CPU data bus.
- Parses framed write commands from the UART byte stream and assembles 32-bit words.
- Holds the CPU core in hold/reset while programming is in progress, and releases it on a run command.
- Sits between the UART receiver, the CPU load/store unit and main_memory.

---
 rtl/uart_mem_boot_ctrl_pkg.sv | 24 ++
 rtl/uart_frame_assembler.sv | 86 ++++++++
 rtl/uart_mem_boot_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_boot_ctrl_pkg.sv
// Shared constants for the UART memory boot loader: FSM state codes, framing bytes and frame lengths.
// UART_MEM_BOOT_CHECKSUM_EN adds a trailing XOR checksum byte (and the CHK state) to every frame.
package uart_mem_boot_ctrl_pkg;

  typedef logic [2:0] boot_state_t;

  localparam boot_state_t ST_IDLE   = 3'd0;
  localparam boot_state_t ST_ADDR_L = 3'd1;
  localparam boot_state_t ST_ADDR_H = 3'd2;
  localparam boot_state_t ST_DATA   = 3'd3;
  localparam boot_state_t ST_WRITE  = 3'd4;
  localparam boot_state_t ST_CHK    = 3'd5;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] RUN_BYTE  = 8'hC3;

  localparam int DATA_BYTES = 4;
`ifdef UART_MEM_BOOT_CHECKSUM_EN
  localparam int FRAME_LEN = 8;
`else
  localparam int FRAME_LEN = 7;
`endif

endpackage

// File: rtl/uart_frame_assembler.sv
// Frame datapath for the boot loader: address/data shift registers and data byte counter.
// With UART_MEM_BOOT_CHECKSUM_EN it also keeps a running XOR of ADDR_L..D3.
module uart_frame_assembler
  import uart_mem_boot_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        start_i,
  input  logic        addr_l_we_i,
  input  logic        addr_h_we_i,
  input  logic        data_we_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] addr_o,
  output logic [31:0] word_o,
  output logic        last_data_o
`ifdef UART_MEM_BOOT_CHECKSUM_EN
  ,
  output logic [7:0]  chk_o
`endif
);

  logic [15:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;
`ifdef UART_MEM_BOOT_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif

  always_comb begin
    addr_d = addr_q;
    word_d = word_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      addr_d = 16'h0000;
      word_d = 32'h0000_0000;
      cnt_d  = 2'd0;
    end else if (addr_l_we_i) begin
      addr_d[7:0] = byte_i;
    end else if (addr_h_we_i) begin
      addr_d[15:8] = byte_i;
      cnt_d        = 2'd0;
    end else if (data_we_i) begin
      // Little-endian: shifting in from the top leaves D0 in [7:0] after four bytes.
      word_d = {byte_i, word_q[31:8]};
      cnt_d  = cnt_q + 2'd1;
    end
  end

`ifdef UART_MEM_BOOT_CHECKSUM_EN
  always_comb begin
    chk_d = chk_q;
    if (start_i) begin
      chk_d = 8'h00;
    end else if (addr_l_we_i || addr_h_we_i || data_we_i) begin
      chk_d = chk_q ^ byte_i;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      chk_q <= 8'h00;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign chk_o = chk_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q <= 16'h0000;
      word_q <= 32'h0000_0000;
      cnt_q  <= 2'd0;
    end else begin
      addr_q <= addr_d;
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o      = addr_q;
  assign word_o      = word_q;
  assign last_data_o = (cnt_q == 2'(DATA_BYTES - 1));

endmodule

// File: rtl/uart_mem_boot_ctrl.sv
// UART boot loader FSM plus memory-port arbiter between the loader and the CPU data bus.
// UART_MEM_BOOT_CHECKSUM_EN selects 8-byte frames with an XOR checksum checked before the address.
module uart_mem_boot_ctrl
  import uart_mem_boot_ctrl_pkg::*;
#(
  parameter int MEMORY_DEPTH = 1024,
  parameter int ADDR_W       = $clog2(MEMORY_DEPTH),
  parameter bit BOOT_HOLD    = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [31:0]       i_cpu_wdata,
  input  logic [3:0]        i_cpu_wsel,
  output logic              o_cpu_ack,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_wsel,
  input  logic              i_mem_ack,
  output logic              o_cpu_hold,
  output logic              o_prog_busy,
  output logic              o_err,
  output logic [15:0]       o_words_written
);

  // Handshake: a UART byte transfers on a cycle where i_rx_valid && o_rx_ready;
  // a memory request stays asserted until the cycle in which i_mem_ack is high.

  localparam logic [16:0] DEPTH_C = 17'(MEMORY_DEPTH);

  boot_state_t state_q, state_d;
  logic        hold_q, hold_d;
  logic        err_q, err_d;
  logic [15:0] words_q, words_d;

  logic        rx_fire;
  logic        addr_ok;
  logic        asm_start, asm_addr_l_we, asm_addr_h_we, asm_data_we;
  logic [15:0] asm_addr;
  logic [31:0] asm_word;
  logic        asm_last;
`ifdef UART_MEM_BOOT_CHECKSUM_EN
  logic [7:0]  asm_chk;
`endif

  uart_frame_assembler u_asm (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .start_i     (asm_start),
    .addr_l_we_i (asm_addr_l_we),
    .addr_h_we_i (asm_addr_h_we),
    .data_we_i   (asm_data_we),
    .byte_i      (i_rx_data),
    .addr_o      (asm_addr),
    .word_o      (asm_word),
    .last_data_o (asm_last)
`ifdef UART_MEM_BOOT_CHECKSUM_EN
    ,
    .chk_o       (asm_chk)
`endif
  );

  assign o_rx_ready = (state_q != ST_WRITE);
  assign rx_fire    = i_rx_valid && o_rx_ready;
  assign addr_ok    = ({1'b0, asm_addr} < DEPTH_C);

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    err_d         = err_q;
    words_d       = words_q;
    asm_start     = 1'b0;
    asm_addr_l_we = 1'b0;
    asm_addr_h_we = 1'b0;
    asm_data_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          if (i_rx_data == SYNC_BYTE) begin
            state_d   = ST_ADDR_L;
            hold_d    = 1'b1;
            asm_start = 1'b1;
          end else if (i_rx_data == RUN_BYTE) begin
            hold_d = 1'b0;
            err_d  = 1'b0;
          end
        end
      end
      ST_ADDR_L: begin
        if (rx_fire) begin
          asm_addr_l_we = 1'b1;
          state_d       = ST_ADDR_H;
        end
      end
      ST_ADDR_H: begin
        if (rx_fire) begin
          asm_addr_h_we = 1'b1;
          state_d       = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_fire) begin
          asm_data_we = 1'b1;
          if (asm_last) begin
`ifdef UART_MEM_BOOT_CHECKSUM_EN
            state_d = ST_CHK;
`else
            if (addr_ok) begin
              state_d = ST_WRITE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
`endif
          end
        end
      end
`ifdef UART_MEM_BOOT_CHECKSUM_EN
      ST_CHK: begin
        if (rx_fire) begin
          // A bad checksum takes precedence over an out-of-range address.
          if ((i_rx_data == asm_chk) && addr_ok) begin
            state_d = ST_WRITE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`endif
      ST_WRITE: begin
        if (i_mem_ack) begin
          state_d = ST_IDLE;
          if (words_q != 16'hFFFF) begin
            words_d = words_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The loader owns the port only while writing; otherwise the CPU passes straight through.
  always_comb begin
    if (state_q == ST_WRITE) begin
      o_mem_req   = 1'b1;
      o_mem_we    = 1'b1;
      o_mem_addr  = asm_addr[ADDR_W-1:0];
      o_mem_wdata = asm_word;
      o_mem_wsel  = 4'hF;
      o_cpu_ack   = 1'b0;
    end else begin
      o_mem_req   = i_cpu_req && !hold_q;
      o_mem_we    = i_cpu_we;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
      o_mem_wsel  = i_cpu_wsel;
      o_cpu_ack   = i_mem_ack;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      hold_q  <= BOOT_HOLD;
      err_q   <= 1'b0;
      words_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

  assign o_cpu_hold      = hold_q;
  assign o_prog_busy     = (state_q != ST_IDLE);
  assign o_err           = err_q;
  assign o_words_written = words_q;

endmodule
